matrix_result_drain: RTL and testbench

//  Reader for the result BRAM filled by the matrix multiplier. After the multiplier signals

---
 rtl/matrix_pkg.sv | 29 ++
 rtl/matrix_result_drain_if.sv | 41 ++++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/matrix_result_drain.sv | 116 +++++++++++
 tb/tb_matrix_result_drain.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix result path.
//   result_word_t  : one result BRAM word, ROW_SIZE lanes of OUTPUT_WIDTH bits, lane 0 in the LSBs
//   addr_t / cnt_t : BRAM address and word counters (counters are one bit wider than the address
//                    so a full-range word count never overflows)
//   drain_state_e  : states of the result drain controller
package matrix_pkg;

  localparam int ROW_SIZE        = 8;
  localparam int OUTPUT_WIDTH    = 32;
  localparam int ADDR_OUTPUT_LEN = 12;
  localparam int WORD_W          = ROW_SIZE * OUTPUT_WIDTH;

  typedef logic [ROW_SIZE-1:0][OUTPUT_WIDTH-1:0] result_word_t;
  typedef logic [ADDR_OUTPUT_LEN-1:0]            addr_t;
  typedef logic [ADDR_OUTPUT_LEN:0]              cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Address of the k-th word of a region; wraps modulo 2^ADDR_OUTPUT_LEN.
  function automatic addr_t word_addr(input addr_t base, input cnt_t k);
    return base + k[ADDR_OUTPUT_LEN-1:0];
  endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// Bundle of the command, BRAM read and output stream signals of matrix_result_drain.
//   start_valid/start_ready/base_addr/word_cnt : start command
//   mem_addr/mem_re/mem_data                   : result BRAM read port
//   out_valid/out_ready/out_data/out_last      : result stream
//   done                                       : command-complete pulse
//   state_dbg/fifo_count_dbg                   : observation of controller state and buffer fill
// Handshake rule for both start_* and out_*: a transfer happens in a cycle where valid and
// ready are both high; the valid side holds its payload stable until that cycle, and valid
// never depends combinationally on ready.
// Modports: slave = the drain block, master = its environment.
interface matrix_result_drain_if;
  import matrix_pkg::*;

  logic         start_valid;
  logic         start_ready;
  addr_t        base_addr;
  addr_t        word_cnt;
  addr_t        mem_addr;
  logic         mem_re;
  result_word_t mem_data;
  logic         out_valid;
  logic         out_ready;
  result_word_t out_data;
  logic         out_last;
  logic         done;
  drain_state_e state_dbg;
  logic [7:0]   fifo_count_dbg;

  modport slave (
    input  start_valid, base_addr, word_cnt, mem_data, out_ready,
    output start_ready, mem_addr, mem_re, out_valid, out_data, out_last, done,
           state_dbg, fifo_count_dbg
  );

  modport master (
    output start_valid, base_addr, word_cnt, mem_data, out_ready,
    input  start_ready, mem_addr, mem_re, out_valid, out_data, out_last, done,
           state_dbg, fifo_count_dbg
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered storage. Works for any DEPTH >= 1.
//   clk, rst_n     : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data : write one entry (ignored when full)
//   pop            : remove the head entry (ignored when empty)
//   head           : current head entry, valid whenever !empty
//   count          : number of stored entries
//   empty/full     : status flags derived from count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths are handled too.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/matrix_result_drain.sv
// Drains a contiguous region of the matrix result BRAM onto a valid/ready stream.
// One start command (base_addr, word_cnt) reads word_cnt words beginning at base_addr,
// absorbing the BRAM read latency and downstream backpressure through a small FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (drops in-flight reads and buffered beats)
//   bus        : matrix_result_drain_if.slave -- start command, BRAM read port, result stream,
//                done pulse, and state/fill observation outputs
// Parameters: BRAM_DELAY (read latency, >= 1), FIFO_DEPTH (>= BRAM_DELAY+2 for full throughput).
module matrix_result_drain
  import matrix_pkg::*;
#(
  parameter int BRAM_DELAY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_result_drain_if.slave  bus
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  // inflight <= BRAM_DELAY < FIFO_DEPTH, so the credit sum fits in one extra bit.
  localparam int UW  = FCW + 1;

  drain_state_e          state;
  addr_t                 base_q;
  cnt_t                  cnt_q;
  cnt_t                  rd_cnt;
  cnt_t                  beat_cnt;
  logic [BRAM_DELAY-1:0] inflight_sr;

  logic [FCW-1:0] fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  result_word_t   fifo_head;

  logic [UW-1:0]  used;
  logic           reads_left;
  logic           issue;
  logic           capture;
  logic           beat;
  logic           last_flag;

  // Credit check from registered counts only: a pop in cycle t is visible to issue in t+1,
  // and there is no combinational path from out_ready to mem_re.
  assign used       = UW'($countones(inflight_sr)) + UW'(fifo_count);
  assign reads_left = (rd_cnt < cnt_q);
  assign issue      = (state == RUN) && reads_left && (used < UW'(FIFO_DEPTH)) && !fifo_full;

  // The oldest in-flight read lands on mem_data in the cycle its bit reaches the tail.
  assign capture    = inflight_sr[BRAM_DELAY-1];
  assign beat       = !fifo_empty && bus.out_ready;
  assign last_flag  = !fifo_empty && ((beat_cnt + cnt_t'(1)) == cnt_q);

  sync_fifo #(
    .WIDTH ($bits(result_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (bus.mem_data),
    .pop       (beat),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      rd_cnt      <= '0;
      beat_cnt    <= '0;
      inflight_sr <= '0;
    end else begin
      // Shift form works for BRAM_DELAY == 1 as well (the old bit simply falls off).
      inflight_sr <= (inflight_sr << 1) | BRAM_DELAY'(issue);
      if (issue) rd_cnt   <= rd_cnt + cnt_t'(1);
      if (beat)  beat_cnt <= beat_cnt + cnt_t'(1);

      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            base_q   <= bus.base_addr;
            cnt_q    <= {1'b0, bus.word_cnt};
            rd_cnt   <= '0;
            beat_cnt <= '0;
            state    <= (bus.word_cnt == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue && ((rd_cnt + cnt_t'(1)) == cnt_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (beat && last_flag) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready    = (state == IDLE);
  assign bus.done           = (state == DONE);
  assign bus.mem_re         = issue;
  assign bus.mem_addr       = word_addr(base_q, rd_cnt);
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_head;
  assign bus.out_last       = last_flag;
  assign bus.state_dbg      = state;
  assign bus.fifo_count_dbg = 8'(fifo_count);

endmodule

// File: tb/tb_matrix_result_drain.sv
`timescale 1ns/1ps
module tb_matrix_result_drain;
  import matrix_pkg::*;

  localparam int D  = 1;
  localparam int FD = 4;
  localparam int PW = WORD_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_result_drain_if bus();

  matrix_result_drain #(.BRAM_DELAY(D), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard queue: {out_last, out_data}
  logic [PW-1:0] exp_q[$];

  function automatic result_word_t word_of(input addr_t a);
    result_word_t w;
    for (int l = 0; l < ROW_SIZE; l++) w[l] = {8'hA0 + 8'(l), 12'h5C3, a};
    return w;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- BRAM model ----------------
  result_word_t bram_pipe [D];
  always @(posedge clk) begin
    bram_pipe[0] <= bus.mem_re ? word_of(bus.mem_addr) : {ROW_SIZE{32'hDEADBEEF}};
    for (int i = 1; i < D; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bus.mem_data = bram_pipe[D-1];

  // ---------------- monitor ----------------
  int            cyc_now = 0;
  int            cyc_base = 0;
  int            rel;
  int            mem_rel_q[$];
  addr_t         mem_addr_q[$];
  int            beat_rel_q[$];
  int            done_rel = -1;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_payload;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start_valid && bus.start_ready) cyc_base = cyc_now;
      rel = cyc_now - cyc_base;
      if (bus.mem_re) begin
        mem_rel_q.push_back(rel);
        mem_addr_q.push_back(bus.mem_addr);
      end
      if (prev_stall) begin
        chk_i("stall_valid_hold", bus.out_valid, 1);
        chk("stall_payload_hold", {bus.out_last, bus.out_data}, prev_payload);
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_rel_q.push_back(rel);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got beat %h expected none", {bus.out_last, bus.out_data});
        end else begin
          chk("beat", {bus.out_last, bus.out_data}, exp_q.pop_front());
        end
      end
      prev_stall   = bus.out_valid && !bus.out_ready;
      prev_payload = {bus.out_last, bus.out_data};
      if (bus.done) begin
        done_rel = rel;
        chk_i("done_excl_start_ready", bus.start_ready, 0);
      end
      chk_i("fifo_bound", (bus.fifo_count_dbg <= FD) ? 1 : 0, 1);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    mem_rel_q.delete();
    mem_addr_q.delete();
    beat_rel_q.delete();
    done_rel = -1;
  endtask

  // Returns at 1ns into cycle 1 (the cycle after the handshake).
  task automatic start_cmd(input addr_t base, input int cnt);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!bus.start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_i("start_ready_before_cmd", bus.start_ready, 1);
    clear_logs();
    for (int k = 0; k < cnt; k++) exp_q.push_back({(k == cnt - 1), word_of(base + addr_t'(k))});
    bus.base_addr   = base;
    bus.word_cnt    = addr_t'(cnt);
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int found;
    found = 0;
    for (int n = 0; n < limit && found == 0; n++) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    chk_i(name, found, 1);
    @(negedge clk);
  endtask

  // ---------------- BRAM_DELAY sweep instances ----------------
  logic       sweep_go = 1'b0;
  logic [1:0] sweep_fin = 2'b00;

  for (genvar g = 0; g < 2; g++) begin : sweep
    localparam int SD = (g == 0) ? 1 : 3;
    matrix_result_drain_if sif();
    matrix_result_drain #(.BRAM_DELAY(SD), .FIFO_DEPTH(SD + 2)) sdut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
    );
    result_word_t pipe [SD];
    always @(posedge clk) begin
      pipe[0] <= sif.mem_re ? word_of(sif.mem_addr) : {ROW_SIZE{32'hDEADBEEF}};
      for (int i = 1; i < SD; i++) pipe[i] <= pipe[i-1];
    end
    assign sif.mem_data = pipe[SD-1];

    initial begin
      int    nb;
      int    first;
      int    lastc;
      int    c;
      int    got;
      addr_t sb;
      sif.start_valid = 1'b0;
      sif.base_addr   = '0;
      sif.word_cnt    = '0;
      sif.out_ready   = 1'b1;
      sb = (g == 0) ? 12'h400 : 12'h7F0;
      wait (sweep_go);
      @(posedge clk); #1;
      chk_i($sformatf("sweep%0d_start_ready", SD), sif.start_ready, 1);
      sif.base_addr   = sb;
      sif.word_cnt    = 12'd32;
      sif.start_valid = 1'b1;
      @(posedge clk); #1;
      sif.start_valid = 1'b0;
      c = 1; nb = 0; first = -1; lastc = -1; got = 0;
      while (got == 0 && c < 200) begin
        @(negedge clk);
        if (sif.out_valid) begin
          chk($sformatf("sweep%0d_beat%0d", SD, nb), {sif.out_last, sif.out_data},
              {(nb == 31), word_of(sb + addr_t'(nb))});
          if (first < 0) first = c;
          lastc = c;
          nb++;
        end
        if (sif.done) got = 1;
        @(posedge clk); #1;
        c++;
      end
      chk_i($sformatf("sweep%0d_done", SD), got, 1);
      chk_i($sformatf("sweep%0d_beats", SD), nb, 32);
      chk_i($sformatf("sweep%0d_first_beat_cycle", SD), first, SD + 2);
      chk_i($sformatf("sweep%0d_no_bubbles", SD), lastc - first, 31);
      sweep_fin[g] = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] pat;
    int         got;
    pat = 4'b1001;
    bus.start_valid = 1'b0;
    bus.base_addr   = '0;
    bus.word_cnt    = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_start_ready", bus.start_ready, 1);
    chk_i("rst_mem_re", bus.mem_re, 0);
    chk_i("rst_mem_addr", bus.mem_addr, 0);
    chk_i("rst_out_valid", bus.out_valid, 0);
    chk_i("rst_out_last", bus.out_last, 0);
    chk_i("rst_done", bus.done, 0);
    chk_i("rst_state", bus.state_dbg, IDLE);
    rst_n = 1'b1;

    // 1) base 0x010, cnt 4, out_ready held high
    bus.out_ready = 1'b1;
    start_cmd(12'h010, 4);
    wait_done(50, "t1_done_seen");
    chk_i("t1_read_count", mem_rel_q.size(), 4);
    chk_i("t1_beat_count", beat_rel_q.size(), 4);
    for (int k = 0; k < 4 && k < mem_rel_q.size(); k++) begin
      chk_i($sformatf("t1_read%0d_cycle", k), mem_rel_q[k], k + 1);
      chk_i($sformatf("t1_read%0d_addr", k), mem_addr_q[k], 'h010 + k);
    end
    for (int k = 0; k < 4 && k < beat_rel_q.size(); k++)
      chk_i($sformatf("t1_beat%0d_cycle", k), beat_rel_q[k], D + 2 + k);
    chk_i("t1_done_cycle", done_rel, D + 6);

    // 2) cnt = 0
    start_cmd(12'h055, 0);
    @(negedge clk);
    chk_i("t2_done_cycle1", bus.done, 1);
    chk_i("t2_start_ready_cycle1", bus.start_ready, 0);
    @(negedge clk);
    chk_i("t2_start_ready_cycle2", bus.start_ready, 1);
    chk_i("t2_done_cycle2", bus.done, 0);
    chk_i("t2_no_reads", mem_rel_q.size(), 0);
    chk_i("t2_no_beats", beat_rel_q.size(), 0);

    // 3) cnt 16 with backpressure 1,0,0,1 then random
    start_cmd(12'h040, 16);
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      bus.out_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.done) got = 1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_i("t3_done_seen", got, 1);
    chk_i("t3_beat_count", beat_rel_q.size(), 16);
    chk_i("t3_queue_drained", exp_q.size(), 0);

    // 4) address wrap
    start_cmd(12'hFFE, 4);
    wait_done(50, "t4_done_seen");
    chk_i("t4_read_count", mem_addr_q.size(), 4);
    if (mem_addr_q.size() == 4) begin
      chk_i("t4_addr0", mem_addr_q[0], 'hFFE);
      chk_i("t4_addr1", mem_addr_q[1], 'hFFF);
      chk_i("t4_addr2", mem_addr_q[2], 'h000);
      chk_i("t4_addr3", mem_addr_q[3], 'h001);
    end

    // 5) reset mid-command with reads in flight and a buffered beat
    bus.out_ready = 1'b0;
    start_cmd(12'h100, 8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_i("t5_pre_reset_valid", bus.out_valid, 1);
    chk_i("t5_pre_reset_mem_re", bus.mem_re, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_i("t5_reset_out_valid", bus.out_valid, 0);
    chk_i("t5_reset_mem_re", bus.mem_re, 0);
    chk_i("t5_reset_start_ready", bus.start_ready, 1);
    exp_q.delete();
    beat_rel_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk_i("t5_no_stale_beats", beat_rel_q.size(), 0);
    chk_i("t5_post_start_ready", bus.start_ready, 1);
    chk_i("t5_post_out_valid", bus.out_valid, 0);
    start_cmd(12'h300, 3);
    wait_done(50, "t5_recover_done_seen");
    chk_i("t5_recover_beats", beat_rel_q.size(), 3);

    // 6) BRAM_DELAY sweep
    sweep_go = 1'b1;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(negedge clk);
      if (sweep_fin == 2'b11) got = 1;
    end
    chk_i("t6_sweep_finished", got, 1);

    chk_i("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
